// File: rtl/csam_pipe_if.sv
// Operand/result stream bundle for the pipelined carry-save array multiplier.
interface csam_pipe_if #(
   parameter int unsigned WX   = 8,
   parameter int unsigned WY   = 5,
   parameter int unsigned TAGW = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WX-1:0]        in_x;
   logic [WY-1:0]        in_y;
   logic                 in_signed;
   logic [TAGW-1:0]      in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [WX+WY-1:0]     out_p;
   logic [TAGW-1:0]      out_tag;

   modport master (
      output in_valid, in_x, in_y, in_signed, in_tag, out_ready,
      input  in_ready, out_valid, out_p, out_tag
   );

   modport slave (
      input  in_valid, in_x, in_y, in_signed, in_tag, out_ready,
      output in_ready, out_valid, out_p, out_tag
   );
endinterface

// File: rtl/csam_pipe.sv
// Pipelined carry-save array multiplier, unsigned or Baugh-Wooley signed per op,
// with a single global stall shared by every stage.
module csam_pipe #(
   parameter int unsigned WX   = 8,
   parameter int unsigned WY   = 5,
   parameter int unsigned RPS  = 1,
   parameter int unsigned TAGW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   csam_pipe_if.slave    bus
);
   localparam int unsigned W = WX + WY;
   localparam int unsigned S = (WY + RPS - 1) / RPS;

   // Baugh-Wooley correction constants split over sum and carry so that the
   // WX-1 / WY-1 columns may coincide without an extra adder.
   localparam logic [W-1:0] K_S = (W'(1) << (WX - 1)) | (W'(1) << (W - 1));
   localparam logic [W-1:0] K_C = W'(1) << (WY - 1);

   logic                advance;

   logic                v_q   [0:S];
   logic [TAGW-1:0]     tag_q [0:S];
   logic                sgn_q [0:S];
   logic [WX-1:0]       x_q   [0:S];
   logic [WY-1:0]       y_q   [0:S];
   logic [W-1:0]        s_q   [0:S];
   logic [W-1:0]        c_q   [0:S];

   logic                v_d   [0:S];
   logic [TAGW-1:0]     tag_d [0:S];
   logic                sgn_d [0:S];
   logic [WX-1:0]       x_d   [0:S];
   logic [WY-1:0]       y_d   [0:S];
   logic [W-1:0]        s_d   [0:S];
   logic [W-1:0]        c_d   [0:S];

   logic [W-1:0]        s_t;
   logic [W-1:0]        c_t;
   logic [W-1:0]        row;
   logic [W-1:0]        carry;
   logic [WX-1:0]       pp;

   assign advance      = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = advance;

   // Stage 0 loads operands; stage k reduces its RPS rows into stage k+1.
   always_comb begin
      s_t   = '0;
      c_t   = '0;
      row   = '0;
      carry = '0;
      pp    = '0;

      v_d[0]   = bus.in_valid;
      tag_d[0] = bus.in_tag;
      sgn_d[0] = bus.in_signed;
      x_d[0]   = bus.in_x;
      y_d[0]   = bus.in_y;
      s_d[0]   = bus.in_signed ? K_S : '0;
      c_d[0]   = bus.in_signed ? K_C : '0;

      for (int unsigned k = 0; k < S; k++) begin
         s_t = s_q[k];
         c_t = c_q[k];
         for (int unsigned r = 0; r < RPS; r++) begin
            if (k * RPS + r < WY) begin
               for (int unsigned i = 0; i < WX; i++) begin
                  pp[i] = (x_q[k][i] & y_q[k][r]) ^
                          (sgn_q[k] & ((i == WX - 1) != (k * RPS + r == WY - 1)));
               end
               row   = W'(pp) << (k * RPS + r);
               carry = ((s_t & c_t) | (s_t & row) | (c_t & row)) << 1;
               s_t   = s_t ^ c_t ^ row;
               c_t   = carry;
            end
         end
         v_d[k+1]   = v_q[k];
         tag_d[k+1] = tag_q[k];
         sgn_d[k+1] = sgn_q[k];
         x_d[k+1]   = x_q[k];
         y_d[k+1]   = y_q[k] >> RPS;
         s_d[k+1]   = s_t;
         c_d[k+1]   = c_t;
      end
   end

   // All stages and the carry-propagate output register move in lockstep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k <= S; k++) begin
            v_q[k]   <= 1'b0;
            tag_q[k] <= '0;
            sgn_q[k] <= 1'b0;
            x_q[k]   <= '0;
            y_q[k]   <= '0;
            s_q[k]   <= '0;
            c_q[k]   <= '0;
         end
         bus.out_valid <= 1'b0;
         bus.out_p     <= '0;
         bus.out_tag   <= '0;
      end else if (advance) begin
         for (int unsigned k = 0; k <= S; k++) begin
            v_q[k]   <= v_d[k];
            tag_q[k] <= tag_d[k];
            sgn_q[k] <= sgn_d[k];
            x_q[k]   <= x_d[k];
            y_q[k]   <= y_d[k];
            s_q[k]   <= s_d[k];
            c_q[k]   <= c_d[k];
         end
         bus.out_valid <= v_q[S];
         bus.out_p     <= s_q[S] + c_q[S];
         bus.out_tag   <= tag_q[S];
      end
   end
endmodule

// File: tb/tb_csam_pipe.sv
// Scoreboard bench for csam_pipe: default build plus a 4x4/RPS=2 build swept exhaustively.
module tb_csam_pipe;
   localparam int unsigned AWX = 8, AWY = 5, ARPS = 1, ATW = 4, AW = 13, AS = 5;
   localparam int unsigned BWX = 4, BWY = 4, BRPS = 2, BTW = 4, BW = 8, BS = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   csam_pipe_if #(.WX(AWX), .WY(AWY), .TAGW(ATW)) ia ();
   csam_pipe_if #(.WX(BWX), .WY(BWY), .TAGW(BTW)) ib ();

   csam_pipe #(.WX(AWX), .WY(AWY), .RPS(ARPS), .TAGW(ATW)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
   csam_pipe #(.WX(BWX), .WY(BWY), .RPS(BRPS), .TAGW(BTW)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

   int    checks   = 0;
   int    failures = 0;
   longint cyc     = 0;
   bit    tog_en   = 1'b0;
   bit    lat_a    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: interpret operands as integers and multiply, wrap to full width.
   function automatic longint model(input longint x, input longint y,
                                    input int wx, input int wy, input bit sg);
      longint xv = x;
      longint yv = y;
      if (sg && (((x >> (wx - 1)) & 1) != 0)) xv = x - (longint'(1) << wx);
      if (sg && (((y >> (wy - 1)) & 1) != 0)) yv = y - (longint'(1) << wy);
      return (xv * yv) & ((longint'(1) << (wx + wy)) - 1);
   endfunction

   logic [AW-1:0]  qa_p[$];
   logic [ATW-1:0] qa_t[$];
   longint         qa_c[$];
   bit             qa_l[$];
   logic [BW-1:0]  qb_p[$];
   logic [BTW-1:0] qb_t[$];
   longint         qb_c[$];

   logic [AW-1:0]  pa;
   logic [ATW-1:0] ta;
   bit             stall_a = 1'b0;

   // Monitor A: handshake rule, stall stability, in-order results and latency.
   always @(negedge clk) begin
      logic [AW-1:0]  ep;
      logic [ATW-1:0] et;
      longint         ec;
      bit             el;
      if (!rst_n) begin
         stall_a = 1'b0;
      end else begin
         checks++;
         if (ia.in_ready !== (!ia.out_valid || ia.out_ready)) begin
            failures++;
            $display("FAIL a_in_ready got=%b want=%b", ia.in_ready, !ia.out_valid || ia.out_ready);
         end
         if (stall_a) begin
            checks++;
            if (ia.out_valid !== 1'b1 || ia.out_p !== pa || ia.out_tag !== ta) begin
               failures++;
               $display("FAIL a_stall_hold got v=%b p=%h t=%h want v=1 p=%h t=%h",
                        ia.out_valid, ia.out_p, ia.out_tag, pa, ta);
            end
         end
         if (ia.out_valid && ia.out_ready) begin
            checks++;
            if (qa_p.size() == 0) begin
               failures++;
               $display("FAIL a_unexpected got p=%h t=%h want no result", ia.out_p, ia.out_tag);
            end else begin
               ep = qa_p.pop_front();
               et = qa_t.pop_front();
               ec = qa_c.pop_front();
               el = qa_l.pop_front();
               if (ia.out_p !== ep) begin
                  failures++;
                  $display("FAIL a_product got=%h want=%h", ia.out_p, ep);
               end
               checks++;
               if (ia.out_tag !== et) begin
                  failures++;
                  $display("FAIL a_tag got=%h want=%h", ia.out_tag, et);
               end
               if (el) begin
                  checks++;
                  if (cyc - ec - 1 != longint'(AS + 1)) begin
                     failures++;
                     $display("FAIL a_latency got=%0d want=%0d", cyc - ec - 1, AS + 1);
                  end
               end
            end
         end
         if (ia.in_valid && ia.in_ready) begin
            qa_p.push_back(AW'(model(longint'(ia.in_x), longint'(ia.in_y), AWX, AWY, ia.in_signed)));
            qa_t.push_back(ia.in_tag);
            qa_c.push_back(cyc);
            qa_l.push_back(lat_a);
         end
         stall_a = ia.out_valid && !ia.out_ready;
         pa      = ia.out_p;
         ta      = ia.out_tag;
      end
   end

   // Monitor B: consumer always ready, so every result also checks latency.
   always @(negedge clk) begin
      logic [BW-1:0]  ep;
      logic [BTW-1:0] et;
      longint         ec;
      if (rst_n) begin
         if (ib.out_valid && ib.out_ready) begin
            checks++;
            if (qb_p.size() == 0) begin
               failures++;
               $display("FAIL b_unexpected got p=%h want no result", ib.out_p);
            end else begin
               ep = qb_p.pop_front();
               et = qb_t.pop_front();
               ec = qb_c.pop_front();
               if (ib.out_p !== ep || ib.out_tag !== et) begin
                  failures++;
                  $display("FAIL b_product got p=%h t=%h want p=%h t=%h", ib.out_p, ib.out_tag, ep, et);
               end
               checks++;
               if (cyc - ec - 1 != longint'(BS + 1)) begin
                  failures++;
                  $display("FAIL b_latency got=%0d want=%0d", cyc - ec - 1, BS + 1);
               end
            end
         end
         if (ib.in_valid && ib.in_ready) begin
            qb_p.push_back(BW'(model(longint'(ib.in_x), longint'(ib.in_y), BWX, BWY, ib.in_signed)));
            qb_t.push_back(ib.in_tag);
            qb_c.push_back(cyc);
         end
      end
   end

   // Pseudo-random consumer backpressure on A.
   always @(posedge clk) begin
      if (tog_en) begin
         #1;
         ia.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_a(input logic [AWX-1:0] x, input logic [AWY-1:0] y,
                         input logic sg, input logic [ATW-1:0] tg, input bit lat);
      bit ok = 1'b0;
      ia.in_valid  = 1'b1;
      ia.in_x      = x;
      ia.in_y      = y;
      ia.in_signed = sg;
      ia.in_tag    = tg;
      lat_a        = lat;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (ia.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL a_accept_timeout got in_ready=0 want 1");
      end
      @(posedge clk);
      #1;
      ia.in_valid = 1'b0;
   endtask

   task automatic send_b(input logic [BWX-1:0] x, input logic [BWY-1:0] y,
                         input logic sg, input logic [BTW-1:0] tg);
      ib.in_valid  = 1'b1;
      ib.in_x      = x;
      ib.in_y      = y;
      ib.in_signed = sg;
      ib.in_tag    = tg;
      @(posedge clk);
      #1;
      ib.in_valid  = 1'b0;
   endtask

   task automatic drain(input bit which);
      bit ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (which == 1'b0 && qa_p.size() == 0 && !ia.out_valid) begin ok = 1'b1; break; end
         if (which == 1'b1 && qb_p.size() == 0 && !ib.out_valid) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL drain_%0d got pending results want none", which);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      rst_n = 1'b0;
      ia.in_valid = 1'b0; ia.in_x = '0; ia.in_y = '0; ia.in_signed = 1'b0; ia.in_tag = '0;
      ia.out_ready = 1'b1;
      ib.in_valid = 1'b0; ib.in_x = '0; ib.in_y = '0; ib.in_signed = 1'b0; ib.in_tag = '0;
      ib.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ia.out_valid !== 1'b0 || ia.out_p !== '0 || ia.out_tag !== '0 || ia.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state got v=%b p=%h t=%h r=%b want v=0 p=0 t=0 r=1",
                  ia.out_valid, ia.out_p, ia.out_tag, ia.in_ready);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed corners, each isolated so latency is exact.
      send_a(8'hFF, 5'h1F, 1'b0, 4'd3, 1'b1); drain(1'b0);
      send_a(8'h80, 5'h10, 1'b1, 4'd5, 1'b1); drain(1'b0);
      send_a(8'h7F, 5'h1F, 1'b1, 4'd6, 1'b1); drain(1'b0);
      send_a(8'h00, 5'h1F, 1'b1, 4'd7, 1'b1); drain(1'b0);
      send_a(8'h80, 5'h0F, 1'b1, 4'd8, 1'b1); drain(1'b0);

      // Back-to-back random mixed-mode stream under backpressure.
      tog_en = 1'b1;
      for (int i = 0; i < 20; i++)
         send_a(AWX'($urandom), AWY'($urandom), 1'($urandom), ATW'(i), 1'b0);
      tog_en = 1'b0;
      @(posedge clk);
      #2;
      ia.out_ready = 1'b1;
      drain(1'b0);

      // Exhaustive sweep of the 4x4 build in both modes.
      for (int sg = 0; sg < 2; sg++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               send_b(BWX'(x), BWY'(y), 1'(sg), BTW'(x + y));
      drain(1'b1);

      // Asynchronous reset with a full, stalled pipeline.
      ia.out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send_a(AWX'($urandom_range(1, 127)), AWY'($urandom_range(1, 15)), 1'($urandom), ATW'(i), 1'b0);
      ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (ia.out_valid) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rst_prefill got out_valid=0 want 1");
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ia.out_valid !== 1'b0 || ia.out_p !== '0 || ia.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL async_reset got v=%b p=%h r=%b want v=0 p=0 r=1",
                  ia.out_valid, ia.out_p, ia.in_ready);
      end
      qa_p.delete(); qa_t.delete(); qa_c.delete(); qa_l.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      ia.out_ready = 1'b1;
      @(posedge clk);
      #1;
      send_a(8'd5, 5'd3, 1'b0, 4'hA, 1'b1);
      drain(1'b0);
      repeat (10) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
